// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller.
// Holds the FSM state encoding, the BCD digit width and the digit type.
// bcd_digit and stopwatch_ctrl both import this package.
package stopwatch_ctrl_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } sw_state_t;
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command and display bundle of the stopwatch.
//   start_stop, lap, clear : single-cycle command pulses into the block
//   ones, tens             : live BCD count
//   disp_ones, disp_tens   : displayed count (the lap snapshot while in LAP)
//   running                : high in RUN and LAP
//   ovf                    : one-cycle pulse after a 99 -> 00 wrap
// Modports:
//   master : the command source and display consumer (the testbench)
//   slave  : the stopwatch block
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic start_stop;
  logic lap;
  logic clear;
  bcd_t ones;
  bcd_t tens;
  bcd_t disp_ones;
  bcd_t disp_tens;
  logic running;
  logic ovf;

  modport master (
    output start_stop, lap, clear,
    input  ones, tens, disp_ones, disp_tens, running, ovf
  );

  modport slave (
    input  start_stop, lap, clear,
    output ones, tens, disp_ones, disp_tens, running, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decimal digit of the stopwatch count.
//   clk, reset : clock and synchronous active-high reset
//   en         : advance the digit by one at the next edge
//   clr        : zero the digit at the next edge; wins over en
//   value      : current digit, always 0..9
//   co         : carry out; high when en is high and value is 9
module bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output bcd_t value,
  output logic co
);

  assign co = en && (value == BCD_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else if (en) begin
      // Compare with >= so a digit can never advance past 9.
      value <= (value >= BCD_MAX) ? '0 : value + BCD_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch with a lap (display freeze) function.
//   TICK_DIV : clk cycles per count tick (1..65535)
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   sw       : command pulses in and count/display/status out (slave modport)
// A prescaler produces one tick every TICK_DIV cycles while the stopwatch
// is in RUN or LAP. Each tick advances the units digit, and a units carry
// advances the tens digit. In LAP the display shows a snapshot taken on
// entry to LAP, while the live count keeps advancing.
// Commands have the priority clear > start_stop > lap. A lower-priority
// command in the same cycle as a higher-priority command is discarded.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  stopwatch_ctrl_if.slave   sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  sw_state_t     state;
  logic [PW-1:0] presc;
  bcd_t          lap_ones;
  bcd_t          lap_tens;
  bcd_t          ones;
  bcd_t          tens;
  logic          active;
  logic          tick;
  logic          co_ones;
  logic          co_tens;
  logic          running;
  logic          ovf;

  assign active = (state == S_RUN) || (state == S_LAP);
  assign tick   = active && (presc == PMAX);

  // clear zeroes both digits directly. A tick in the same cycle as clear
  // is therefore dropped.
  bcd_digit u_ones (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .clr   (sw.clear),
    .value (ones),
    .co    (co_ones)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .reset (reset),
    .en    (co_ones),
    .clr   (sw.clear),
    .value (tens),
    .co    (co_tens)
  );

  always_ff @(posedge clk) begin
    if (reset || sw.clear) begin
      state    <= S_IDLE;
      running  <= 1'b0;
      ovf      <= 1'b0;
      presc    <= '0;
      lap_ones <= '0;
      lap_tens <= '0;
    end else begin
      // co_tens is high only on a tick at 99, so ovf pulses in the cycle after the wrap.
      ovf <= co_tens;
      // The prescaler advances in every RUN/LAP cycle, including a cycle in
      // which start_stop leaves RUN/LAP, so that cycle's tick still counts.
      if (active) presc <= tick ? '0 : presc + PW'(1);
      case (state)
        S_IDLE: begin
          if (sw.start_stop) begin
            state   <= S_RUN;
            running <= 1'b1;
            presc   <= '0;
          end
        end
        S_RUN: begin
          if (sw.start_stop) begin
            state   <= S_PAUSE;
            running <= 1'b0;
          end else if (sw.lap) begin
            state    <= S_LAP;
            lap_ones <= ones;
            lap_tens <= tens;
          end
        end
        S_LAP: begin
          if (sw.start_stop) begin
            state   <= S_PAUSE;
            running <= 1'b0;
          end else if (sw.lap) begin
            state <= S_RUN;
          end
        end
        S_PAUSE: begin
          // Resume without touching the prescaler, so the tick phase is kept.
          if (sw.start_stop) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign sw.ones      = ones;
  assign sw.tens      = tens;
  assign sw.disp_ones = (state == S_LAP) ? lap_ones : ones;
  assign sw.disp_tens = (state == S_LAP) ? lap_tens : tens;
  assign sw.running   = running;
  assign sw.ovf       = ovf;

endmodule
